// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Shares a single I2C master wrapper (one SDA/SCL pair) between several
// requesters. A requester owns the bus for a whole multi-command sequence;
// ownership is granted round-robin, and a watchdog reclaims the bus from an
// owner that holds it longer than p_timeout_cycles.
//
// Ports
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_req / o_gnt                     per-requester request, one-hot grant
//   i_cmd_valid/i_cmd_data/o_cmd_ready  per-requester command channel
//   i_wr_valid/i_wr_data/o_wr_ready     per-requester write-byte channel
//   o_rd_valid/o_rd_data/i_rd_ready     read channel (data broadcast)
//   o_m_cmd_* / o_m_wr_* / *_m_rd_*     single channel set to the master
//   i_m_busy                          master is executing a transaction
//   o_owner                           index of the current or last owner
//   o_timeout                         one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int p_num_req        = 2,
  // Width of the master's packed command word (t_i2c_cmd).
  parameter int p_cmd_width      = 24,
  parameter int p_timeout_cycles = 2_500_000,
  parameter int p_cnt_width      = $clog2(p_timeout_cycles + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [p_num_req-1:0]             i_req,
  output logic [p_num_req-1:0]             o_gnt,
  input  logic [p_num_req-1:0]             i_cmd_valid,
  input  logic [p_num_req*p_cmd_width-1:0] i_cmd_data,
  output logic [p_num_req-1:0]             o_cmd_ready,
  input  logic [p_num_req-1:0]             i_wr_valid,
  input  logic [p_num_req*8-1:0]           i_wr_data,
  output logic [p_num_req-1:0]             o_wr_ready,
  output logic [p_num_req-1:0]             o_rd_valid,
  output logic [7:0]                       o_rd_data,
  input  logic [p_num_req-1:0]             i_rd_ready,
  output logic                             o_m_cmd_valid,
  output logic [p_cmd_width-1:0]           o_m_cmd_data,
  input  logic                             i_m_cmd_ready,
  output logic                             o_m_wr_valid,
  output logic [7:0]                       o_m_wr_data,
  input  logic                             i_m_wr_ready,
  input  logic                             i_m_rd_valid,
  input  logic [7:0]                       i_m_rd_data,
  output logic                             o_m_rd_ready,
  input  logic                             i_m_busy,
  output logic [$clog2(p_num_req)-1:0]     o_owner,
  output logic                             o_timeout
);

  localparam int ow = $clog2(p_num_req);
  localparam logic [p_cnt_width-1:0] cnt_max = p_cnt_width'(p_timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [p_num_req-1:0]   gnt_q, gnt_d;
  logic [p_num_req-1:0]   mask_q, mask_d;
  logic [ow-1:0]          owner_q, owner_d;
  logic [ow-1:0]          last_q, last_d;
  logic [p_cnt_width-1:0] cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;

  // Round-robin search: first eligible requester starting at last+1.
  logic [p_num_req-1:0] eligible;
  logic                 found;
  logic [ow-1:0]        win;

  assign eligible = i_req & ~mask_q;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int i = 1; i <= p_num_req; i++) begin
      int idx;
      idx = (int'(last_q) + i) % p_num_req;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = ow'(idx);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    // A mask bit only survives while its requester keeps requesting.
    mask_d    = mask_q & i_req;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          owner_d    = win;
          last_d     = win;
          state_d    = OWNED;
        end
      end
      OWNED: begin
        // Release wins over a simultaneous timeout.
        if (!i_req[owner_q]) begin
          gnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == cnt_max) begin
          timeout_d       = 1'b1;
          gnt_d           = '0;
          mask_d[owner_q] = 1'b1;
          state_d         = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!i_m_busy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      mask_q    <= '0;
      owner_q   <= '0;
      last_q    <= ow'(p_num_req - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mask_q    <= mask_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Datapath mux. Commands and write bytes pass only while the owner still
  // requests, so a command pending at the moment of release is never
  // forwarded. Reads keep routing through DRAIN so an in-flight byte lands.
  logic fwd_en;
  logic rd_en;

  assign fwd_en = (state_q == OWNED) && i_req[owner_q];
  assign rd_en  = (state_q == OWNED) || (state_q == DRAIN);

  always_comb begin
    o_m_cmd_valid = 1'b0;
    o_m_cmd_data  = '0;
    o_m_wr_valid  = 1'b0;
    o_m_wr_data   = '0;
    o_m_rd_ready  = 1'b0;
    o_cmd_ready   = '0;
    o_wr_ready    = '0;
    o_rd_valid    = '0;
    if (fwd_en) begin
      o_m_cmd_valid        = i_cmd_valid[owner_q];
      o_m_cmd_data         = i_cmd_data[owner_q*p_cmd_width +: p_cmd_width];
      o_cmd_ready[owner_q] = i_m_cmd_ready;
      o_m_wr_valid         = i_wr_valid[owner_q];
      o_m_wr_data          = i_wr_data[owner_q*8 +: 8];
      o_wr_ready[owner_q]  = i_m_wr_ready;
    end
    if (rd_en) begin
      o_rd_valid[owner_q] = i_m_rd_valid;
      o_m_rd_ready        = i_rd_ready[owner_q];
    end
  end

  assign o_rd_data = i_m_rd_data;
  assign o_gnt     = gnt_q;
  assign o_owner   = owner_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_arbiter
//
// Directed bench for i2c_bus_arbiter with two requesters and a 100-cycle
// watchdog. Inputs change just after the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_i2c_bus_arbiter;

  localparam int N  = 2;
  localparam int CW = 16;
  localparam int TO = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [N-1:0]    cmd_valid;
  logic [N*CW-1:0] cmd_data;
  logic [N-1:0]    cmd_ready;
  logic [N-1:0]    wr_valid;
  logic [N*8-1:0]  wr_data;
  logic [N-1:0]    wr_ready;
  logic [N-1:0]    rd_valid;
  logic [7:0]      rd_data;
  logic [N-1:0]    rd_ready;
  logic            m_cmd_valid;
  logic [CW-1:0]   m_cmd_data;
  logic            m_cmd_ready;
  logic            m_wr_valid;
  logic [7:0]      m_wr_data;
  logic            m_wr_ready;
  logic            m_rd_valid;
  logic [7:0]      m_rd_data;
  logic            m_rd_ready;
  logic            m_busy;
  logic [0:0]      owner;
  logic            timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .p_num_req       (N),
    .p_cmd_width     (CW),
    .p_timeout_cycles(TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_gnt        (gnt),
    .i_cmd_valid  (cmd_valid),
    .i_cmd_data   (cmd_data),
    .o_cmd_ready  (cmd_ready),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .o_rd_valid   (rd_valid),
    .o_rd_data    (rd_data),
    .i_rd_ready   (rd_ready),
    .o_m_cmd_valid(m_cmd_valid),
    .o_m_cmd_data (m_cmd_data),
    .i_m_cmd_ready(m_cmd_ready),
    .o_m_wr_valid (m_wr_valid),
    .o_m_wr_data  (m_wr_data),
    .i_m_wr_ready (m_wr_ready),
    .i_m_rd_valid (m_rd_valid),
    .i_m_rd_data  (m_rd_data),
    .o_m_rd_ready (m_rd_ready),
    .i_m_busy     (m_busy),
    .o_owner      (owner),
    .o_timeout    (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end of test, required finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst         = 1'b1;
    req         = 2'b11;
    cmd_valid   = '0;
    cmd_data    = '0;
    wr_valid    = '0;
    wr_data     = '0;
    rd_ready    = '0;
    m_cmd_ready = 1'b0;
    m_wr_ready  = 1'b0;
    m_rd_valid  = 1'b0;
    m_rd_data   = '0;
    m_busy      = 1'b0;

    // ---- Reset state -----------------------------------------------------
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_m_cmd_valid", 32'(m_cmd_valid), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_owner", 32'(owner), 32'h0);

    // ---- Requester 0: three commands with one write byte each -----------
    m_cmd_ready = 1'b1;
    m_wr_ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 2'b11;                               // non-owner also valid
      cmd_data  = {16'hBEEF, 16'(16'h1000 + k)};
      wr_valid  = 2'b11;
      wr_data   = {8'hEE, 8'(8'h50 + k)};
      #1;
      check("cmd_valid_fwd", 32'(m_cmd_valid), 32'h1);
      check("cmd_data_fwd", 32'(m_cmd_data), 32'h1000 + k);
      check("cmd_ready_vec", 32'(cmd_ready), 32'h1);
      check("wr_valid_fwd", 32'(m_wr_valid), 32'h1);
      check("wr_data_fwd", 32'(m_wr_data), 32'h50 + k);
      check("wr_ready_vec", 32'(wr_ready), 32'h1);
      tick();
    end
    wr_valid = '0;

    // ---- Release with a command pending: not forwarded ---------------------
    cmd_valid   = 2'b01;
    m_cmd_ready = 1'b0;
    req         = 2'b10;
    #1;
    check("release_no_cmd", 32'(m_cmd_valid), 32'h0);
    check("release_no_ready", 32'(cmd_ready), 32'h0);
    tick();
    cmd_valid = '0;
    check("drain_gnt", 32'(gnt), 32'h0);
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("gnt_to_1", 32'(gnt), 32'h2);
    check("owner_1", 32'(owner), 32'h1);

    // ---- Requester 1 read --------------------------------------------------
    m_rd_valid = 1'b1;
    m_rd_data  = 8'hA5;
    rd_ready   = 2'b10;
    #1;
    check("rd_valid_vec", 32'(rd_valid), 32'h2);
    check("rd_data", 32'(rd_data), 32'hA5);
    check("m_rd_ready_on", 32'(m_rd_ready), 32'h1);
    rd_ready = 2'b01;                                  // only non-owner ready
    #1;
    check("m_rd_ready_stall", 32'(m_rd_ready), 32'h0);
    check("rd_valid_hold", 32'(rd_valid), 32'h2);
    m_rd_valid = 1'b0;
    rd_ready   = '0;
    tick();

    // ---- Release while master busy for 20 cycles --------------------------
    req    = 2'b01;
    m_busy = 1'b1;
    tick();
    // In DRAIN: reads still reach owner 1, commands are blocked.
    m_rd_valid  = 1'b1;
    rd_ready    = 2'b10;
    cmd_valid   = 2'b11;
    m_cmd_ready = 1'b1;
    #1;
    check("drain_rd_valid", 32'(rd_valid), 32'h2);
    check("drain_m_rd_ready", 32'(m_rd_ready), 32'h1);
    check("drain_no_cmd", 32'(m_cmd_valid), 32'h0);
    check("drain_no_cmd_ready", 32'(cmd_ready), 32'h0);
    m_rd_valid  = 1'b0;
    rd_ready    = '0;
    cmd_valid   = '0;
    m_cmd_ready = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      check("busy_no_gnt", 32'(gnt), 32'h0);
    end
    m_busy = 1'b0;
    tick();
    check("busy_fall_idle", 32'(gnt), 32'h0);
    tick();
    check("busy_fall_gnt", 32'(gnt), 32'h1);
    check("busy_fall_owner", 32'(owner), 32'h0);

    // ---- Watchdog: owner 0 holds, requester 1 pending ---------------------
    req = 2'b11;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("wd_hold_gnt", 32'(gnt), 32'h1);
      check("wd_hold_no_to", 32'(timeout), 32'h0);
    end
    tick();
    check("wd_fire_gnt", 32'(gnt), 32'h0);
    check("wd_fire_pulse", 32'(timeout), 32'h1);
    tick();
    check("wd_pulse_end", 32'(timeout), 32'h0);
    tick();
    check("wd_gnt_to_1", 32'(gnt), 32'h2);
    check("wd_owner_1", 32'(owner), 32'h1);

    // Requester 1 releases; masked requester 0 must not be regranted.
    req = 2'b01;
    tick();
    tick();
    tick();
    check("mask_no_regnt_a", 32'(gnt), 32'h0);
    tick();
    check("mask_no_regnt_b", 32'(gnt), 32'h0);
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    check("mask_cleared_gnt", 32'(gnt), 32'h1);

    // ---- Asynchronous reset mid-command -----------------------------------
    req       = 2'b11;
    cmd_valid = 2'b01;
    cmd_data  = {16'h2222, 16'h1234};
    #1;
    check("pre_rst_cmd_valid", 32'(m_cmd_valid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_m_cmd_valid", 32'(m_cmd_valid), 32'h0);
    check("arst_m_cmd_data", 32'(m_cmd_data), 32'h0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("arst_owner", 32'(owner), 32'h0);
    check("arst_timeout", 32'(timeout), 32'h0);
    tick();
    cmd_valid = '0;
    rst       = 1'b0;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    check("post_rst_owner", 32'(owner), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
